// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and constants for the iterative AES-128 round
//               sequencer: FSM state encoding, round count and round-key RAM
//               address width.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int AES_NR        = 10;
   localparam int AES_RK_ADDR_W = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEXP  = 3'd1,
      LOAD  = 3'd2,
      ROUND = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } aes_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_round_counter.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_counter
// Description : Loadable up-counter with synchronous clear and a terminal-
//               count compare against a programmable limit.
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-low reset (count -> 0)
//               clr    - clear count to 0 (highest priority)
//               ld     - load ld_val
//               ld_val - load value
//               inc    - increment by one (saturates at all-ones, never wraps)
//               limit  - terminal-count compare value
//               count  - current count
//               tc     - count == limit
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (ld) begin
         count <= ld_val;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

   assign tc = (count == limit);

endmodule
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Control sequencer for an iterative AES-128 encryption
//               datapath. Orders key expansion into the round-key RAM, the
//               initial AddRoundKey, NR-1 full rounds and the final round
//               without MixColumns, then holds the result until accepted.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-low reset
//               start     - encrypt request, accepted when in_ready=1
//               key_new   - pulse: cipher key changed, round keys stale
//               out_ready - consumer accepts the ciphertext
//               in_ready  - high only in IDLE
//               busy      - high in every state except IDLE
//               ks_wr     - key-expansion step, writes round key ks_addr
//               ks_addr   - round-key RAM write address
//               rk_addr   - round-key RAM read address
//               ld_state  - load state register with plaintext ^ key 0
//               st_en     - state register round update enable
//               mix_en    - MixColumns enable (0 = final-round path)
//               out_valid - ciphertext valid in the state register
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR     = AES_NR,
   parameter int ADDR_W = AES_RK_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              key_new,
   input  logic              out_ready,
   output logic              in_ready,
   output logic              busy,
   output logic              ks_wr,
   output logic [ADDR_W-1:0] ks_addr,
   output logic [ADDR_W-1:0] rk_addr,
   output logic              ld_state,
   output logic              st_en,
   output logic              mix_en,
   output logic              out_valid
);

   localparam logic [ADDR_W-1:0] KS_LIMIT = ADDR_W'(NR);
   localparam logic [ADDR_W-1:0] RK_LIMIT = ADDR_W'(NR - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   // The counters must be able to reach NR without wrapping, and at least
   // one full round must exist before the final round.
   generate
      if ((NR >= (1 << ADDR_W)) || (NR < 2)) begin : g_param_check
         $error("aes_round_sequencer: NR must satisfy 2 <= NR < 2**ADDR_W");
      end
   endgenerate

   aes_seq_state_t state;
   logic           keys_valid;
   logic           key_pend;

   logic accept;
   logic need_kexp;
   logic ks_clr, ks_ld, ks_inc, ks_tc;
   logic rk_clr, rk_ld, rk_inc, rk_tc;

   assign accept    = (state == IDLE) && start;
   // key_new in the accepting cycle counts too, so a simultaneous key change
   // is never missed.
   assign need_kexp = !keys_valid || key_pend || key_new;

   // Key-expansion address: 1..NR during KEXP, 0 otherwise.
   assign ks_ld  = accept && need_kexp;
   assign ks_inc = (state == KEXP) && !ks_tc;
   assign ks_clr = (state == KEXP) && ks_tc;

   // Round-key read address: 0 in LOAD, r=1..NR-1 in ROUND, NR in FINAL
   // (the last ROUND increment lands on NR), 0 again from DONE on.
   assign rk_ld  = (state == LOAD);
   assign rk_inc = (state == ROUND);
   assign rk_clr = (state == FINAL);

   aes_round_counter #(
      .WIDTH (ADDR_W)
   ) u_ks_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (ks_clr),
      .ld     (ks_ld),
      .ld_val (ADDR_ONE),
      .inc    (ks_inc),
      .limit  (KS_LIMIT),
      .count  (ks_addr),
      .tc     (ks_tc)
   );

   aes_round_counter #(
      .WIDTH (ADDR_W)
   ) u_rk_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (rk_clr),
      .ld     (rk_ld),
      .ld_val (ADDR_ONE),
      .inc    (rk_inc),
      .limit  (RK_LIMIT),
      .count  (rk_addr),
      .tc     (rk_tc)
   );

   // Outputs are registered alongside the state so each one is valid for
   // the whole cycle of the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         keys_valid <= 1'b0;
         key_pend   <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         ks_wr      <= 1'b0;
         ld_state   <= 1'b0;
         st_en      <= 1'b0;
         mix_en     <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         // A key change at any time marks the RAM stale; the accepting IDLE
         // branch below overrides this when it starts the expansion itself.
         if (key_new) begin
            key_pend <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (need_kexp) begin
                     state    <= KEXP;
                     ks_wr    <= 1'b1;
                     key_pend <= 1'b0;
                  end else begin
                     state    <= LOAD;
                     ld_state <= 1'b1;
                  end
               end
            end

            KEXP: begin
               if (ks_tc) begin
                  ks_wr      <= 1'b0;
                  keys_valid <= 1'b1;
                  ld_state   <= 1'b1;
                  state      <= LOAD;
               end
            end

            LOAD: begin
               ld_state <= 1'b0;
               st_en    <= 1'b1;
               mix_en   <= 1'b1;
               state    <= ROUND;
            end

            ROUND: begin
               if (rk_tc) begin
                  mix_en <= 1'b0;
                  state  <= FINAL;
               end
            end

            FINAL: begin
               st_en     <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               ks_wr     <= 1'b0;
               ld_state  <= 1'b0;
               st_en     <= 1'b0;
               mix_en    <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_sequencer
// Description : Testbench for aes_round_sequencer. A small behavioural AES
//               datapath is driven by the sequencer's control outputs; the
//               resulting ciphertext and the per-cycle control timeline are
//               compared against expectations queued at each accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

   localparam int NR = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       key_new = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, busy, ks_wr, ld_state, st_en, mix_en, out_valid;
   logic [3:0] ks_addr, rk_addr;

   aes_round_sequencer #(
      .NR     (NR),
      .ADDR_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_new   (key_new),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .busy      (busy),
      .ks_wr     (ks_wr),
      .ks_addr   (ks_addr),
      .rk_addr   (rk_addr),
      .ld_state  (ld_state),
      .st_en     (st_en),
      .mix_en    (mix_en),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;

   // ---------------- AES reference arithmetic ----------------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254, then the AES affine transform.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = sbox_t[s[127-8*(r+4*((c+r)%4)) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
         o[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] k, input int i);
      logic [7:0]  rc = 8'h01;
      logic [31:0] w0, w1, w2, w3, t;
      for (int j = 1; j < i; j++) rc = xt(rc);
      {w0, w1, w2, w3} = k;
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      t ^= {rc, 24'h0};
      w0 ^= t;
      w1 ^= w0;
      w2 ^= w1;
      w3 ^= w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] k = key;
      logic [127:0] s = pt ^ key;
      for (int r = 1; r <= NR; r++) begin
         k = next_rk(k, r);
         s = sub_shift(s);
         if (r < NR) s = mix_cols(s);
         s ^= k;
      end
      return s;
   endfunction

   // ---------------- Datapath driven by the sequencer ----------------
   logic [127:0] cipher_key = '0;
   logic [127:0] data_in    = '0;
   logic [127:0] ram [16];
   logic [127:0] dp_state   = '0;

   always @(posedge clk) begin
      if (ks_wr) begin
         if (ks_addr == 4'd1) begin
            ram[0] <= cipher_key;
            ram[1] <= next_rk(cipher_key, 1);
         end else begin
            ram[ks_addr] <= next_rk(ram[ks_addr - 4'd1], int'(ks_addr));
         end
      end
      if (ld_state)
         dp_state <= data_in ^ ram[rk_addr];
      else if (st_en)
         dp_state <= mix_en ? (mix_cols(sub_shift(dp_state)) ^ ram[rk_addr])
                            : (sub_shift(dp_state) ^ ram[rk_addr]);
   end

   // ---------------- Scoreboard queues and key model ----------------
   logic [127:0] exp_q [$];
   bit           ctl_q [$];
   bit           m_keys_valid = 1'b0;
   bit           m_key_pend   = 1'b0;
   logic [127:0] m_exp_key    = '0;

   function automatic logic [14:0] pk(input logic ir, input logic b, input logic kw,
                                      input logic [3:0] ka, input logic [3:0] ra,
                                      input logic ld, input logic st, input logic mx,
                                      input logic ov);
      return {ir, b, kw, ka, ra, ld, st, mx, ov};
   endfunction

   // Output monitor: ciphertext check at every completed handshake.
   logic [127:0] out_exp;
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got=%h required=none", dp_state);
         end else begin
            out_exp = exp_q.pop_front();
            if (dp_state !== out_exp) begin
               errors++;
               $display("FAIL ciphertext got=%h required=%h", dp_state, out_exp);
            end
         end
      end
   end

   // Control timeline monitor: cycle t after acceptance, E expansion cycles.
   bit         active = 1'b0;
   int         t_m = 0;
   int         cur_e = 0;
   logic       e_ir, e_b, e_kw, e_ld, e_st, e_mx, e_ov;
   logic [3:0] e_ka, e_ra;
   logic [14:0] got_v, req_v;
   always @(negedge clk) begin
      if (!rst) begin
         active = 1'b0;
      end else begin
         if (!active && ctl_q.size() > 0) begin
            cur_e  = ctl_q.pop_front() ? NR : 0;
            active = 1'b1;
            t_m    = 1;
         end
         {e_ir, e_b, e_kw, e_ld, e_st, e_mx, e_ov} = 7'b0100000;
         e_ka = 4'd0;
         e_ra = 4'd0;
         if (!active) begin
            e_ir = 1'b1;
            e_b  = 1'b0;
         end else if (t_m <= cur_e) begin
            e_kw = 1'b1;
            e_ka = 4'(t_m);
         end else if (t_m == cur_e + 1) begin
            e_ld = 1'b1;
         end else if (t_m <= cur_e + NR) begin
            e_st = 1'b1;
            e_mx = 1'b1;
            e_ra = 4'(t_m - cur_e - 1);
         end else if (t_m == cur_e + NR + 1) begin
            e_st = 1'b1;
            e_ra = 4'(NR);
         end else begin
            e_ov = 1'b1;
         end
         got_v = pk(in_ready, busy, ks_wr, ks_addr, rk_addr, ld_state, st_en, mix_en, out_valid);
         req_v = pk(e_ir, e_b, e_kw, e_ka, e_ra, e_ld, e_st, e_mx, e_ov);
         tests++;
         if (got_v !== req_v) begin
            errors++;
            $display("FAIL ctl_timeline t=%0d active=%0d got=%h required=%h",
                     t_m, active, got_v, req_v);
         end
         if (active) begin
            if (e_ov && out_ready) active = 1'b0;
            else t_m++;
         end
      end
   end

   // ---------------- Stimulus ----------------
   task automatic check_reset_outputs(input string name);
      got_v = pk(in_ready, busy, ks_wr, ks_addr, rk_addr, ld_state, st_en, mix_en, out_valid);
      tests++;
      if (got_v !== pk(1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got_v,
                  pk(1, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0));
      end
   endtask

   task automatic accept_start(input logic [127:0] pt, input bit kn, input logic [127:0] kkey,
                               input bit use_fixed, input logic [127:0] fixed_ct);
      int  n = 0;
      bit  kexp;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++;
         errors++;
         $display("FAIL accept_wait got=in_ready_low required=in_ready_high");
      end
      data_in = pt;
      start   = 1'b1;
      if (kn) begin
         key_new    = 1'b1;
         cipher_key = kkey;
      end
      @(posedge clk); #1;
      start   = 1'b0;
      key_new = 1'b0;
      kexp = !m_keys_valid || m_key_pend || kn;
      if (kexp) begin
         m_exp_key    = cipher_key;
         m_keys_valid = 1'b1;
         m_key_pend   = 1'b0;
      end
      ctl_q.push_back(kexp);
      exp_q.push_back(use_fixed ? fixed_ct : aes_ref(pt, m_exp_key));
   endtask

   task automatic finish_txn(input int kn_at, input logic [127:0] kkey,
                             input int hold, input bit spam);
      int t = 1;
      int held = 0;
      bit done = 1'b0;
      out_ready = (hold == 0);
      while (!done && t < 100) begin
         key_new = (t == kn_at);
         if (t == kn_at) begin
            cipher_key = kkey;
            m_key_pend = 1'b1;
         end
         start = 1'b0;
         if (out_valid) begin
            start = spam;
            if (held < hold) begin
               out_ready = 1'b0;
               held++;
            end else begin
               out_ready = 1'b1;
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
         t++;
      end
      start     = 1'b0;
      key_new   = 1'b0;
      out_ready = 1'b0;
      if (!done) begin
         tests++;
         errors++;
         $display("FAIL txn_timeout got=no_out_valid required=out_valid");
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] k2, pt;
      int n;
      for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

      // Reset state, applied asynchronously away from any clock edge.
      #2 rst = 1'b0;
      #1 check_reset_outputs("reset_state");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 vector with cold keys: full expansion then encryption.
      cipher_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      accept_start(128'h3243f6a8885a308d313198a2e0370734, 1'b0, '0,
                   1'b1, 128'h3925841d02dc09fbdc118597196a0b32);
      finish_txn(-1, '0, 0, 1'b0);

      // Keys valid, no key change: no expansion.
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 0, 1'b0);

      // Key change mid-encryption: result uses old keys, next start expands.
      k2 = rnd128();
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(5, k2, 0, 1'b0);
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 0, 1'b0);

      // Back-pressure in DONE with start pulses that must be ignored.
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 7, 1'b1);

      // Asynchronous reset mid-ROUND at rk_addr=4.
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      n = 0;
      while (rk_addr != 4'd4 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (rk_addr != 4'd4) begin
         errors++;
         $display("FAIL reach_round4 got=%0d required=4", rk_addr);
      end
      @(negedge clk); #1;
      rst = 1'b0;
      #1 check_reset_outputs("mid_round_reset");
      exp_q.delete();
      ctl_q.delete();
      m_keys_valid = 1'b0;
      m_key_pend   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Keys cleared by reset: expansion again.
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 0, 1'b0);

      // start and key_new together, then a plain start without expansion.
      accept_start(rnd128(), 1'b1, rnd128(), 1'b0, '0);
      finish_txn(-1, '0, 0, 1'b0);
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 0, 1'b0);

      // key_new during KEXP forces a re-expansion at the next start.
      accept_start(rnd128(), 1'b1, rnd128(), 1'b0, '0);
      finish_txn(5, rnd128(), 0, 1'b0);
      accept_start(rnd128(), 1'b0, '0, 1'b0, '0);
      finish_txn(-1, '0, 1, 1'b0);

      // Randomized mix of key changes, back-pressure and busy starts.
      for (int i = 0; i < 8; i++) begin
         int  kmode;
         kmode = $urandom_range(0, 2);
         pt    = rnd128();
         accept_start(pt, kmode == 2, rnd128(), 1'b0, '0);
         finish_txn((kmode == 1) ? $urandom_range(2, 15) : -1, rnd128(),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0 || ctl_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations got=%0d/%0d required=0/0",
                  exp_q.size(), ctl_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Top-level sequencer for the iterative AES-128 encryption datapath: one state register, one round per cycle, round keys read from the round-key RAM.
- Orders key expansion (RAM fill), initial AddRoundKey, NR-1 full rounds and the final round without MixColumns.
- Presents a start/ready input handshake and a valid/ready output handshake to the system bus wrapper.

Parameters:
- NR, 10, number of AES rounds. The round-key RAM holds keys 0..NR.
- ADDR_W, 4, round-key address width. Must satisfy 2^ADDR_W > NR.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request to encrypt the block on the data input. Accepted only when in_ready=1.
- key_new  input  1  pulse: the cipher key register changed, so the round keys are stale.
- out_ready  input  1  consumer accepts the ciphertext.
- in_ready  output  1  high only in IDLE.
- busy  output  1  high in every state except IDLE.
- ks_wr  output  1  key-expansion step: the expander computes and writes round key ks_addr.
- ks_addr  output  ADDR_W  round-key RAM write address.
- rk_addr  output  ADDR_W  round-key RAM read address.
- ld_state  output  1  load the state register with plaintext XOR round key 0.
- st_en  output  1  state register update enable for a round.
- mix_en  output  1  MixColumns enable. 0 selects the final-round path.
- out_valid  output  1  ciphertext valid in the state register.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, keys_valid=0, key_pend=0.
  - All outputs 0 except in_ready=1. ks_addr and rk_addr are 0.
  - Reset mid-operation aborts immediately. No output completes.
- States: IDLE, KEXP, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - start=1 with (keys_valid=0 or key_pend=1 or key_new=1) -> KEXP, ks_addr=1, key_pend cleared.
  - start=1 otherwise -> LOAD.
- KEXP:
  - ks_wr=1 for exactly NR cycles, ks_addr=1,2,..,NR in order.
  - After the cycle with ks_addr=NR: keys_valid=1, -> LOAD.
- LOAD: one cycle, rk_addr=0, ld_state=1, st_en=0. -> ROUND with round counter r=1.
- ROUND:
  - rk_addr=r, st_en=1, mix_en=1.
  - r increments each cycle. When r=NR-1 -> FINAL.
- FINAL: one cycle, rk_addr=NR, st_en=1, mix_en=0. -> DONE.
- DONE:
  - out_valid=1, held until out_ready=1 in the same cycle, then -> IDLE.
  - The state register is frozen: st_en=0, ld_state=0.
- Latency, keys valid, start accepted in cycle 0:
  - LOAD in cycle 1, ROUND in cycles 2..NR, FINAL in cycle NR+1.
  - out_valid first high in cycle NR+2 (cycle 12 for NR=10).
  - With expansion, add NR cycles (out_valid in cycle 22).
- Idle output values: rk_addr and ks_addr hold 0 whenever their enables are low; mix_en=0 outside ROUND.
- key_new while busy:
  - Sets key_pend and leaves the current operation unchanged; it uses the old keys.
  - Expansion runs at the next accepted start.
  - key_new during KEXP also sets key_pend, which forces a re-expansion at the next start.
- start while busy (including DONE): ignored and not queued.
- start and key_new in the same IDLE cycle: expansion runs.
- out_ready while out_valid=0: ignored.
- Counters:
  - ADDR_W-bit, no wrap. They never exceed NR.
  - A synthesis-time check errors if NR >= 2^ADDR_W.

Decomposition:
- Package aes_pkg:
  - state enum type aes_seq_state_t (IDLE..DONE).
  - Constants AES_NR=10 and AES_RK_ADDR_W=4.
- One sub-module, aes_round_counter:
  - Loadable up-counter with clear, inc and terminal-count compare against a programmable limit.
  - Instantiated twice: for ks_addr (limit NR) and rk_addr/r (limit NR-1).
- FSM and output decode stay in aes_round_sequencer.

Test Plan:
- Reset then start=1 for one cycle with keys_valid=0 -> ks_wr high for 10 cycles, ks_addr 1..10; LOAD with rk_addr=0, ld_state=1; rk_addr 1..9 with mix_en=1; rk_addr=10 with mix_en=0; out_valid at cycle 22; with out_ready=1 -> in_ready=1 next cycle.
- Second start with no key_new -> no ks_wr pulse, out_valid at cycle 12. Compare the ciphertext of the full datapath against the FIPS-197 vector 3243f6a8885a308d313198a2e0370734 / 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32.
- key_new pulse at cycle 5 of an encryption -> current result unchanged. Next start performs the 10-cycle KEXP before LOAD.
- Hold out_ready=0 for 7 cycles in DONE, with start pulses during DONE -> out_valid stays 1, st_en=0, starts ignored. Release out_ready -> IDLE, exactly one result.
- Assert rst=0 asynchronously mid-ROUND (rk_addr=4) -> all outputs 0 and in_ready=1 immediately. Next start performs KEXP because keys_valid was cleared.
- start and key_new in the same IDLE cycle -> KEXP entered, and key_pend=0 afterwards.
